packet_sink: RTL
================

Name: packet_sink

Overview:
- Synthesizable receive end of the credit-based NoC link that packet sources drive.
- Detects packet start from the diff-pair toggle and assembles 5 consecutive 32-bit flits into one 160-bit packet.
- Buffers up to CREDITS complete packets and presents them downstream on a valid/ready interface.
- Returns one credit pulse per packet consumed.

Parameters:
- CREDITS, 4: packet buffer depth; equals the credits initially granted to the upstream source.
- FLIT_WIDTH, 32: bits per flit.
- FLITS_PER_PACKET, 5: flits per packet. PACKET_WIDTH = FLIT_WIDTH*FLITS_PER_PACKET = 160.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- diff_pair_in  in  2  packet-start marker. Legal values are 2'b10 and 2'b01; a change between them starts a packet.
- channel_in  in  FLIT_WIDTH  flit data, one flit per cycle.
- credit_out  out  1  one-cycle pulse per packet freed; feeds the source's credit_in.
- pkt_valid  out  1  head-of-buffer packet available.
- pkt_data  out  PACKET_WIDTH  head packet; flit i at [FLIT_WIDTH*i +: FLIT_WIDTH].
- pkt_ready  in  1  downstream accepts the head packet.
- overflow_err  out  1  sticky; a packet completed while the buffer was full.
- framing_err  out  1  sticky; a start toggle occurred mid-packet.

Behaviour:
- Reset (async, any time): the following values apply.
  - credit_out=0, pkt_valid=0, pkt_data=0, overflow_err=0, framing_err=0.
  - dp_prev=2'b10.
  - FSM=IDLE, flit count=0, buffer pointers and occupancy=0.
  - Any partial packet is discarded and no credit is issued for it.
- Start detect:
  - start = (diff_pair_in is 2'b01 or 2'b10) && (diff_pair_in != dp_prev).
  - dp_prev updates only on legal values. 2'b00 and 2'b11 are ignored.
- FSM IDLE: on start at posedge, capture channel_in as flit 0, set count=1, go to RECV.
- FSM RECV: each posedge captures channel_in as flit[count] and increments count.
  - When flit 4 is captured, the packet is complete. Push it to the buffer and go to IDLE, or stay in RECV if start is asserted on that edge. No gap cycle is required between packets.
- Start while in RECV with count in 1..4:
  - Set framing_err.
  - Discard the partial packet.
  - Treat the current channel_in as flit 0 of a new packet (count=1).
- Push latency: flit 4 captured at posedge N gives pkt_valid=1 with the correct pkt_data after edge N, if the buffer was empty.
- Buffer: circular, CREDITS entries, read pointer (rd) and write pointer (wr) wrap at CREDITS, occupancy 0..CREDITS.
  - pkt_valid = (occupancy != 0).
  - pkt_data = entry[rd].
- Pop: at a posedge with pkt_valid && pkt_ready, advance rd, decrement occupancy, and drive credit_out=1 for exactly the next cycle.
  - Back-to-back pops give back-to-back credit pulses, one per packet.
- Simultaneous push and pop on one edge: occupancy unchanged and both pointers advance. This is legal when full: the pop frees the slot in the same edge.
- Push with occupancy==CREDITS and no simultaneous pop: the packet is dropped, overflow_err is set, and no pointer moves.
- pkt_ready while pkt_valid=0: no effect and no credit.
- Sticky errors clear only on reset.
- No combinational path from inputs to outputs other than pkt_data and pkt_valid, which come from buffer state.

Decomposition:
- Shared include (alongside system.vh / packet_type.vh) holds the constants FLITS_PER_PACKET, PACKET_WIDTH, the diff-pair reset value 2'b10, and the flit-slice macro for flit i.
- One natural sub-module, packet_fifo: parameterized depth/width register FIFO with push, pop, full, empty and occupancy. packet_sink keeps the FSM, the assembly register and the credit/error logic.

Test Plan:
- Single packet: toggle 10->01 with flits 0x11111111..0x55555555 on 5 consecutive edges -> after the 5th edge pkt_valid=1 and pkt_data=0x55555555_44444444_33333333_22222222_11111111; pkt_ready=1 gives one credit_out pulse, then pkt_valid=0.
- Fill and backpressure: 4 packets with pkt_ready=0 -> occupancy 4, no credits. Send a 5th -> overflow_err=1 and the buffer holds packets 1-4 unchanged. Then release pkt_ready -> 4 consecutive credit pulses, in order.
- Full with simultaneous push/pop: buffer full, pkt_ready=1 on the 5th packet's last-flit edge -> no overflow, occupancy stays 4, and packet 5 is delivered after 2-4.
- Back-to-back: 3 packets with toggles 10->01->10->01 and no idle cycles -> 3 packets with correct data, framing_err=0.
- Framing: toggle again after flit 2 -> framing_err=1, the partial packet is dropped, and the next 5 flits form one valid packet.
- Reset mid-packet: assert reset after flit 3 -> all outputs reach their reset values immediately (asynchronously) and no credit is issued. The next packet after release is received correctly, starting from dp_prev=2'b10.

Source files
------------

// File: rtl/packet_sink_pkg.sv
// packet_sink_pkg: shared link constants, FSM state type and flit-slice helper
package packet_sink_pkg;
    localparam int DEF_FLIT_WIDTH = 32;
    localparam int DEF_FLITS_PER_PACKET = 5;
    localparam int DEF_PACKET_WIDTH = DEF_FLIT_WIDTH * DEF_FLITS_PER_PACKET;
    localparam logic [1:0] DP_RESET = 2'b10;
    typedef enum logic {IDLE, RECV} state_t;
    function automatic int flit_base(input int i, input int w);
        return i * w;
    endfunction
endpackage

// File: rtl/packet_sink_fifo.sv
// packet_sink_fifo: circular register FIFO holding complete packets
module packet_sink_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 160
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam int NW = $clog2(DEPTH + 1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] rd, wr;
    logic [NW-1:0] occupancy;
    logic do_push, do_pop;
    // a pop on the same edge frees the slot, so a push into a full buffer is still accepted
    always_comb begin
        full = occupancy == NW'(DEPTH);
        empty = occupancy == '0;
        do_pop = pop && !empty;
        do_push = push && (!full || do_pop);
        dout = empty ? '0 : mem[rd];
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd <= '0;
            wr <= '0;
            occupancy <= '0;
        end else begin
            if (do_push) wr <= wr == AW'(DEPTH - 1) ? '0 : wr + AW'(1);
            if (do_pop) rd <= rd == AW'(DEPTH - 1) ? '0 : rd + AW'(1);
            if (do_push != do_pop) occupancy <= do_push ? occupancy + NW'(1) : occupancy - NW'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push) mem[wr] <= din;
    end
endmodule

// File: rtl/packet_sink.sv
// packet_sink: NoC link receiver assembling flits into packets with credit return
module packet_sink
    import packet_sink_pkg::*;
#(
    parameter int CREDITS = 4,
    parameter int FLIT_WIDTH = DEF_FLIT_WIDTH,
    parameter int FLITS_PER_PACKET = DEF_FLITS_PER_PACKET,
    localparam int PACKET_WIDTH = FLIT_WIDTH * FLITS_PER_PACKET
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [1:0]              diff_pair_in,
    input  logic [FLIT_WIDTH-1:0]   channel_in,
    output logic                    credit_out,
    output logic                    pkt_valid,
    output logic [PACKET_WIDTH-1:0] pkt_data,
    input  logic                    pkt_ready,
    output logic                    overflow_err,
    output logic                    framing_err
);
    localparam int CW = $clog2(FLITS_PER_PACKET);
    localparam int AB = FLIT_WIDTH * (FLITS_PER_PACKET - 1);
    localparam logic [CW-1:0] LAST = CW'(FLITS_PER_PACKET - 1);
    state_t state, state_n;
    logic [1:0] dp_prev;
    logic [CW-1:0] count, count_n, slot;
    logic [AB-1:0] asm_q;
    logic legal, start, capture, push, pop, full, empty;
    // the last flit bypasses the assembly register straight into the buffer
    always_comb begin
        legal = diff_pair_in[1] ^ diff_pair_in[0];
        start = legal && diff_pair_in != dp_prev;
        pkt_valid = !empty;
        pop = pkt_valid && pkt_ready;
        state_n = state;
        count_n = count;
        capture = 1'b0;
        push = 1'b0;
        if (start) begin
            state_n = RECV;
            count_n = CW'(1);
            capture = 1'b1;
        end else if (state == RECV) begin
            capture = 1'b1;
            push = count == LAST;
            state_n = push ? IDLE : RECV;
            count_n = push ? '0 : count + CW'(1);
        end
        slot = start ? '0 : count;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            dp_prev <= DP_RESET;
            asm_q <= '0;
            credit_out <= 1'b0;
            overflow_err <= 1'b0;
            framing_err <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            if (legal) dp_prev <= diff_pair_in;
            credit_out <= pop;
            overflow_err <= overflow_err | (push && full && !pop);
            framing_err <= framing_err | (start && state == RECV);
            for (int i = 0; i < FLITS_PER_PACKET - 1; i++)
                if (capture && slot == CW'(i)) asm_q[flit_base(i, FLIT_WIDTH) +: FLIT_WIDTH] <= channel_in;
        end
    end
    packet_sink_fifo #(.DEPTH(CREDITS), .WIDTH(PACKET_WIDTH)) u_fifo (
        .clk(clk),
        .reset(reset),
        .push(push),
        .pop(pop),
        .din({channel_in, asm_q}),
        .dout(pkt_data),
        .full(full),
        .empty(empty)
    );
endmodule
